mc_ctrl: RTL and testbench

- Multi-cycle main controller for the MIPS datapath.
- Sequences each instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB.
- Drives the datapath select lines: MemToRegsel (ALU/DM/PC+4/ext), RegDstsel (rt/rd/$31) and AluSrcsel (rs2/ext), plus all write enables.
- Sits beside the register file, ALU and data-memory interface; handshakes with data memory through dm_req/dm_ready.

---
 rtl/mc_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: IDLE/FETCH/DECODE/EXEC/MEM/WB sequencer with Moore datapath decodes.
// Optional performance counters (instr_cnt, stall_cnt) are enabled by defining MC_CTRL_PERF_EN.
module mc_ctrl #(
  parameter int DM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        dm_ready,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic [1:0]  NPCOp,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        dm_req,
  output logic [1:0]  MemToRegsel,
  output logic [1:0]  RegDstsel,
  output logic        AluSrcsel,
  output logic [2:0]  ALUOp,
  output logic [1:0]  ExtOp,
  output logic        err,
`ifdef MC_CTRL_PERF_EN
  output logic [31:0] instr_cnt,
  output logic [31:0] stall_cnt,
`endif
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [3:0] DM_CNT_MAX = 4'(DM_TIMEOUT);

  state_t     r_state;
  state_t     w_nstate;
  logic [3:0] r_dmCnt;

  logic       w_rAluFn;
  logic [2:0] w_rAluOp;
  logic       w_isRAlu, w_isJr, w_isOri, w_isLui, w_isLw, w_isSw;
  logic       w_isBeq, w_isJ, w_isJal, w_legal, w_timeout;

  // The branch decision (PCWriteCond & zero) is formed in the datapath, not here.
  logic       w_unused_zero;
  assign w_unused_zero = zero;

  always_comb begin
    w_rAluFn = 1'b1;
    w_rAluOp = 3'b000;
    case (funct)
      FN_ADDU: w_rAluOp = 3'b000;
      FN_SUBU: w_rAluOp = 3'b001;
      FN_AND:  w_rAluOp = 3'b010;
      FN_OR:   w_rAluOp = 3'b011;
      FN_SLT:  w_rAluOp = 3'b100;
      default: w_rAluFn = 1'b0;
    endcase
  end

  assign w_isRAlu  = (opcode == OP_RTYPE) && w_rAluFn;
  assign w_isJr    = (opcode == OP_RTYPE) && (funct == FN_JR);
  assign w_isOri   = (opcode == OP_ORI);
  assign w_isLui   = (opcode == OP_LUI);
  assign w_isLw    = (opcode == OP_LW);
  assign w_isSw    = (opcode == OP_SW);
  assign w_isBeq   = (opcode == OP_BEQ);
  assign w_isJ     = (opcode == OP_J);
  assign w_isJal   = (opcode == OP_JAL);
  assign w_legal   = w_isRAlu | w_isJr | w_isOri | w_isLui | w_isLw | w_isSw |
                     w_isBeq | w_isJ | w_isJal;
  assign w_timeout = (r_dmCnt == DM_CNT_MAX) && !dm_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nstate;
  end

  // Counts MEM cycles spent waiting; held at zero outside MEM so every access starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_dmCnt <= 4'd0;
    else if (r_state != MEM)                   r_dmCnt <= 4'd0;
    else if (!dm_ready && r_dmCnt != DM_CNT_MAX) r_dmCnt <= r_dmCnt + 4'd1;
  end

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      IDLE:   w_nstate = FETCH;
      FETCH:  w_nstate = DECODE;
      DECODE: w_nstate = (!w_legal || w_isJ || w_isJal) ? FETCH : EXEC;
      EXEC: begin
        if (w_isLw || w_isSw)       w_nstate = MEM;
        else if (w_isBeq || w_isJr) w_nstate = FETCH;
        else                        w_nstate = WB;
      end
      MEM: begin
        if (dm_ready)       w_nstate = w_isLw ? WB : FETCH;
        else if (w_timeout) w_nstate = FETCH;
      end
      WB:      w_nstate = FETCH;
      default: w_nstate = IDLE;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    NPCOp       = 2'b00;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    MemWrite    = 1'b0;
    dm_req      = 1'b0;
    MemToRegsel = 2'b00;
    RegDstsel   = 2'b00;
    AluSrcsel   = 1'b0;
    ALUOp       = 3'b000;
    ExtOp       = 2'b00;
    err         = 1'b0;
    case (r_state)
      FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
      end
      DECODE: begin
        err = !w_legal;
        if (w_isJ || w_isJal) begin
          PCWrite = 1'b1;
          NPCOp   = 2'b10;
        end
        if (w_isJal) begin
          RegWrite    = 1'b1;
          RegDstsel   = 2'b10;
          MemToRegsel = 2'b10;
        end
      end
      EXEC: begin
        if (w_isRAlu) ALUOp = w_rAluOp;
        if (w_isJr) begin
          PCWrite = 1'b1;
          NPCOp   = 2'b11;
        end
        if (w_isOri) begin
          AluSrcsel = 1'b1;
          ALUOp     = 3'b011;
        end
        if (w_isLui) ExtOp = 2'b10;
        if (w_isLw || w_isSw) begin
          AluSrcsel = 1'b1;
          ExtOp     = 2'b01;
        end
        if (w_isBeq) begin
          ALUOp       = 3'b001;
          PCWriteCond = 1'b1;
          NPCOp       = 2'b01;
        end
      end
      MEM: begin
        err      = w_timeout;
        dm_req   = !w_timeout;
        MemWrite = w_isSw && !w_timeout;
      end
      WB: begin
        RegWrite  = 1'b1;
        RegDstsel = w_isRAlu ? 2'b01 : 2'b00;
        if (w_isLw) MemToRegsel = 2'b01;
        // lui writes back extout directly, so the extender must keep producing imm<<16 here.
        if (w_isLui) begin
          MemToRegsel = 2'b11;
          ExtOp       = 2'b10;
        end
      end
      default: ;
    endcase
  end

  assign state_o = r_state;

`ifdef MC_CTRL_PERF_EN
  logic [31:0] r_instrCnt;
  logic [31:0] r_stallCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instrCnt <= 32'd0;
      r_stallCnt <= 32'd0;
    end else begin
      if (r_state == FETCH)             r_instrCnt <= r_instrCnt + 32'd1;
      if (r_state == MEM && !dm_ready)  r_stallCnt <= r_stallCnt + 32'd1;
    end
  end

  assign instr_cnt = r_instrCnt;
  assign stall_cnt = r_stallCnt;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed testbench for mc_ctrl: walks each instruction class cycle by cycle against hand-computed control vectors.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, funct;
  logic        zero, dm_ready;
  logic        PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite, dm_req, AluSrcsel, err;
  logic [1:0]  NPCOp, MemToRegsel, RegDstsel, ExtOp;
  logic [2:0]  ALUOp, state_o;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] instr_cnt, stall_cnt;
`endif

  int nCompared   = 0;
  int nMismatched = 0;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;

  mc_ctrl #(.DM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .dm_ready(dm_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .NPCOp(NPCOp),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .dm_req(dm_req),
    .MemToRegsel(MemToRegsel), .RegDstsel(RegDstsel), .AluSrcsel(AluSrcsel),
    .ALUOp(ALUOp), .ExtOp(ExtOp), .err(err),
`ifdef MC_CTRL_PERF_EN
    .instr_cnt(instr_cnt), .stall_cnt(stall_cnt),
`endif
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  // All observable outputs packed into one word so a whole cycle is compared at once.
  logic [21:0] obs;
  assign obs = {state_o, err, PCWrite, PCWriteCond, NPCOp, IRWrite, RegWrite, MemWrite,
                dm_req, MemToRegsel, RegDstsel, AluSrcsel, ALUOp, ExtOp};

  function automatic logic [21:0] ctl(input logic [2:0] st, input logic er, input logic pcw,
                                      input logic pcwc, input logic [1:0] npc, input logic irw,
                                      input logic rw, input logic mw, input logic req,
                                      input logic [1:0] m2r, input logic [1:0] rdst,
                                      input logic asrc, input logic [2:0] alu,
                                      input logic [1:0] ext);
    return {st, er, pcw, pcwc, npc, irw, rw, mw, req, m2r, rdst, asrc, alu, ext};
  endfunction

  logic [21:0] vIdle, vFetch, vDec, vExecMem, vMemLw, vMemSw, vWbLw;
  initial begin
    vIdle    = ctl(3'd0, N, N, N, 2'b00, N, N, N, N, 2'b00, 2'b00, N, 3'b000, 2'b00);
    vFetch   = ctl(3'd1, N, Y, N, 2'b00, Y, N, N, N, 2'b00, 2'b00, N, 3'b000, 2'b00);
    vDec     = ctl(3'd2, N, N, N, 2'b00, N, N, N, N, 2'b00, 2'b00, N, 3'b000, 2'b00);
    vExecMem = ctl(3'd3, N, N, N, 2'b00, N, N, N, N, 2'b00, 2'b00, Y, 3'b000, 2'b01);
    vMemLw   = ctl(3'd4, N, N, N, 2'b00, N, N, N, Y, 2'b00, 2'b00, N, 3'b000, 2'b00);
    vMemSw   = ctl(3'd4, N, N, N, 2'b00, N, N, Y, Y, 2'b00, 2'b00, N, 3'b000, 2'b00);
    vWbLw    = ctl(3'd5, N, N, N, 2'b00, N, Y, N, N, 2'b01, 2'b00, N, 3'b000, 2'b00);
  end

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
  endtask

  task automatic test_reset();
    logic [21:0] ev[4];
    rst_n = 1'b1; zero = 1'b0; dm_ready = 1'b0;
    applyStimulus(6'b000010, 6'b000000);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    nCompared++;
    if (obs !== vIdle) begin
      nMismatched++;
      $display("[TB] FAIL reset_idle got %h want %h", obs, vIdle);
    end
    ev[0] = vIdle; ev[1] = vFetch;
    ev[2] = ctl(3'd2, N, Y, N, 2'b10, N, N, N, N, 2'b00, 2'b00, N, 3'b000, 2'b00);
    ev[3] = vFetch;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      nCompared++;
      if (obs !== ev[i]) begin
        nMismatched++;
        $display("[TB] FAIL reset_seq cyc%0d got %h want %h", i, obs, ev[i]);
      end
      if (i < 3) @(negedge clk);
    end
  endtask

  task automatic test_rtype(input logic [5:0] fn, input logic [2:0] alu);
    logic [21:0] ev[5];
    applyStimulus(6'b000000, fn);
    dm_ready = 1'b0;
    ev[0] = vFetch; ev[1] = vDec;
    ev[2] = ctl(3'd3, N, N, N, 2'b00, N, N, N, N, 2'b00, 2'b00, N, alu, 2'b00);
    ev[3] = ctl(3'd5, N, N, N, 2'b00, N, Y, N, N, 2'b00, 2'b01, N, 3'b000, 2'b00);
    ev[4] = vFetch;
    for (int i = 0; i < 5; i++) begin
      #1;
      nCompared++;
      if (obs !== ev[i]) begin
        nMismatched++;
        $display("[TB] FAIL rtype_%b cyc%0d got %h want %h", fn, i, obs, ev[i]);
      end
      if (i < 4) @(negedge clk);
    end
  endtask

  task automatic test_imm(input logic [5:0] op, input logic [21:0] execV, input logic [21:0] wbV);
    logic [21:0] ev[5];
    applyStimulus(op, 6'b000000);
    dm_ready = 1'b0;
    ev[0] = vFetch; ev[1] = vDec; ev[2] = execV; ev[3] = wbV; ev[4] = vFetch;
    for (int i = 0; i < 5; i++) begin
      #1;
      nCompared++;
      if (obs !== ev[i]) begin
        nMismatched++;
        $display("[TB] FAIL imm_%b cyc%0d got %h want %h", op, i, obs, ev[i]);
      end
      if (i < 4) @(negedge clk);
    end
  endtask

  // waits = MEM cycles with dm_ready low before it rises; lw always completes here.
  task automatic test_lw_wait(input int waits);
    logic [21:0] ev[24];
    logic        rdy[24];
    int          n;
    applyStimulus(6'b100011, 6'b000000);
    n = waits + 6;
    for (int i = 0; i < 24; i++) rdy[i] = 1'b0;
    ev[0] = vFetch; ev[1] = vDec; ev[2] = vExecMem;
    for (int i = 3; i <= 3 + waits; i++) ev[i] = vMemLw;
    rdy[3 + waits] = 1'b1;
    ev[4 + waits] = vWbLw;
    ev[5 + waits] = vFetch;
    for (int i = 0; i < n; i++) begin
      dm_ready = rdy[i];
      #1;
      nCompared++;
      if (obs !== ev[i]) begin
        nMismatched++;
        $display("[TB] FAIL lw_w%0d cyc%0d got %h want %h", waits, i, obs, ev[i]);
      end
      if (i < n - 1) @(negedge clk);
    end
    dm_ready = 1'b0;
  endtask

  task automatic test_sw_ready();
    logic [21:0] ev[5];
    applyStimulus(6'b101011, 6'b000000);
    ev[0] = vFetch; ev[1] = vDec; ev[2] = vExecMem; ev[3] = vMemSw; ev[4] = vFetch;
    for (int i = 0; i < 5; i++) begin
      dm_ready = (i == 3);
      #1;
      nCompared++;
      if (obs !== ev[i]) begin
        nMismatched++;
        $display("[TB] FAIL sw_ready cyc%0d got %h want %h", i, obs, ev[i]);
      end
      if (i < 4) @(negedge clk);
    end
    dm_ready = 1'b0;
  endtask

  task automatic test_sw_timeout();
    logic [21:0] ev[20];
    applyStimulus(6'b101011, 6'b000000);
    dm_ready = 1'b0;
    ev[0] = vFetch; ev[1] = vDec; ev[2] = vExecMem;
    for (int i = 3; i < 18; i++) ev[i] = vMemSw;
    ev[18] = ctl(3'd4, Y, N, N, 2'b00, N, N, N, N, 2'b00, 2'b00, N, 3'b000, 2'b00);
    ev[19] = vFetch;
    for (int i = 0; i < 20; i++) begin
      #1;
      nCompared++;
      if (obs !== ev[i]) begin
        nMismatched++;
        $display("[TB] FAIL sw_timeout cyc%0d got %h want %h", i, obs, ev[i]);
      end
      if (i < 19) @(negedge clk);
    end
  endtask

  task automatic test_jal();
    logic [21:0] ev[3];
    applyStimulus(6'b000011, 6'b000000);
    dm_ready = 1'b1;
    ev[0] = vFetch;
    ev[1] = ctl(3'd2, N, Y, N, 2'b10, N, Y, N, N, 2'b10, 2'b10, N, 3'b000, 2'b00);
    ev[2] = vFetch;
    for (int i = 0; i < 3; i++) begin
      #1;
      nCompared++;
      if (obs !== ev[i]) begin
        nMismatched++;
        $display("[TB] FAIL jal cyc%0d got %h want %h", i, obs, ev[i]);
      end
      if (i < 2) @(negedge clk);
    end
    dm_ready = 1'b0;
  endtask

  task automatic test_branch(input logic [5:0] fn, input logic [5:0] op, input logic [21:0] execV);
    logic [21:0] ev[4];
    applyStimulus(op, fn);
    zero = 1'b0;
    ev[0] = vFetch; ev[1] = vDec; ev[2] = execV; ev[3] = vFetch;
    for (int i = 0; i < 4; i++) begin
      #1;
      nCompared++;
      if (obs !== ev[i]) begin
        nMismatched++;
        $display("[TB] FAIL branch_%b cyc%0d got %h want %h", op, i, obs, ev[i]);
      end
      if (i < 3) @(negedge clk);
    end
  endtask

  task automatic test_illegal(input logic [5:0] op, input logic [5:0] fn);
    logic [21:0] ev[3];
    applyStimulus(op, fn);
    ev[0] = vFetch;
    ev[1] = ctl(3'd2, Y, N, N, 2'b00, N, N, N, N, 2'b00, 2'b00, N, 3'b000, 2'b00);
    ev[2] = vFetch;
    for (int i = 0; i < 3; i++) begin
      #1;
      nCompared++;
      if (obs !== ev[i]) begin
        nMismatched++;
        $display("[TB] FAIL illegal_%b_%b cyc%0d got %h want %h", op, fn, i, obs, ev[i]);
      end
      if (i < 2) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [21:0] ev[4];
    applyStimulus(6'b100011, 6'b000000);
    dm_ready = 1'b0;
    ev[0] = vFetch; ev[1] = vDec; ev[2] = vExecMem; ev[3] = vMemLw;
    for (int i = 0; i < 4; i++) begin
      #1;
      nCompared++;
      if (obs !== ev[i]) begin
        nMismatched++;
        $display("[TB] FAIL midmem_pre cyc%0d got %h want %h", i, obs, ev[i]);
      end
      if (i < 3) @(negedge clk);
    end
    #1 rst_n = 1'b0;
    #1;
    nCompared++;
    if (dm_req !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL midmem_dmreq got %b want 0", dm_req);
    end
    nCompared++;
    if (obs !== vIdle) begin
      nMismatched++;
      $display("[TB] FAIL midmem_idle got %h want %h", obs, vIdle);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    nCompared++;
    if (obs !== vIdle) begin
      nMismatched++;
      $display("[TB] FAIL midmem_release got %h want %h", obs, vIdle);
    end
    @(negedge clk);
    #1;
    nCompared++;
    if (obs !== vFetch) begin
      nMismatched++;
      $display("[TB] FAIL midmem_refetch got %h want %h", obs, vFetch);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_rtype(6'b100001, 3'b000);
    test_rtype(6'b100011, 3'b001);
    test_rtype(6'b101010, 3'b100);
    test_imm(6'b001101,
             ctl(3'd3, N, N, N, 2'b00, N, N, N, N, 2'b00, 2'b00, Y, 3'b011, 2'b00),
             ctl(3'd5, N, N, N, 2'b00, N, Y, N, N, 2'b00, 2'b00, N, 3'b000, 2'b00));
    test_imm(6'b001111,
             ctl(3'd3, N, N, N, 2'b00, N, N, N, N, 2'b00, 2'b00, N, 3'b000, 2'b10),
             ctl(3'd5, N, N, N, 2'b00, N, Y, N, N, 2'b11, 2'b00, N, 3'b000, 2'b10));
    test_lw_wait(3);
    test_lw_wait(15);
    test_sw_ready();
    test_sw_timeout();
    test_jal();
    test_branch(6'b000000, 6'b000100,
                ctl(3'd3, N, N, Y, 2'b01, N, N, N, N, 2'b00, 2'b00, N, 3'b001, 2'b00));
    test_branch(6'b001000, 6'b000000,
                ctl(3'd3, N, Y, N, 2'b11, N, N, N, N, 2'b00, 2'b00, N, 3'b000, 2'b00));
    test_illegal(6'b111111, 6'b000000);
    test_illegal(6'b000000, 6'b000000);
    test_reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
